mesh_2d_pipe: RTL and testbench

MESH_2D_PIPE -- requirements
Module: mesh_2d_pipe

---
 rtl/mesh_pkg.sv | 38 +++
 rtl/mesh_link_fifo.sv | 46 ++++
 rtl/mesh_2d_pipe.sv | 59 +++++
 tb/tb_mesh_2d_pipe.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mesh_pkg.sv
// mesh_pkg: port-direction constants, opposite-port and node-index helpers for the 2D mesh
package mesh_pkg;
    localparam int EAST  = 0;
    localparam int SOUTH = 1;
    localparam int WEST  = 2;
    localparam int NORTH = 3;

    function automatic int opposite(input int p);
        return (p + 2) % 4;
    endfunction

    function automatic int node_idx(input int x, input int y, input int h);
        return y * h + x;
    endfunction

    // Neighbour node with wrap-around; callers decide whether the wrap is a real link.
    function automatic int nb_node(input int n, input int p, input int h, input int v);
        int x;
        int y;
        x = n % h;
        y = n / h;
        return p == EAST  ? node_idx((x + 1) % h, y, h) :
               p == WEST  ? node_idx((x + h - 1) % h, y, h) :
               p == SOUTH ? node_idx(x, (y + 1) % v, h) :
                            node_idx(x, (y + v - 1) % v, h);
    endfunction

    function automatic bit on_edge(input int n, input int p, input int h, input int v);
        int x;
        int y;
        x = n % h;
        y = n / h;
        return p == EAST  ? (x == h - 1) :
               p == WEST  ? (x == 0) :
               p == SOUTH ? (y == v - 1) :
                            (y == 0);
    endfunction
endpackage

// File: rtl/mesh_link_fifo.sv
// mesh_link_fifo: unidirectional link buffer with valid/ready on both sides and registered occupancy
module mesh_link_fifo #(
    parameter int DATA_W     = 37,
    parameter int LINK_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o
);
    localparam int AW = $clog2(LINK_DEPTH);
    localparam logic [AW:0] FULL = LINK_DEPTH[AW:0];

    logic [DATA_W-1:0] mem [LINK_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              push;
    logic              pop;

    assign ready_o = count != FULL;
    assign valid_o = count != '0;
    assign data_o  = valid_o ? mem[rd_ptr] : '0;
    assign push    = valid_i && ready_o;
    assign pop     = valid_o && ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_i;
    end
endmodule

// File: rtl/mesh_2d_pipe.sv
// mesh_2d_pipe: buffered link fabric of an H_SIZE x V_SIZE mesh; MESH_TORUS_EN adds wrap links
module mesh_2d_pipe
    import mesh_pkg::*;
#(
    parameter int H_SIZE     = 2,
    parameter int V_SIZE     = 2,
    parameter int DATA_W     = 37,
    parameter int LINK_DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [H_SIZE*V_SIZE*4*DATA_W-1:0] data_i,
    input  logic [H_SIZE*V_SIZE*4-1:0]        valid_i,
    output logic [H_SIZE*V_SIZE*4-1:0]        ready_o,
    output logic [H_SIZE*V_SIZE*4*DATA_W-1:0] data_o,
    output logic [H_SIZE*V_SIZE*4-1:0]        valid_o,
    input  logic [H_SIZE*V_SIZE*4-1:0]        ready_i
);
    localparam int NODES_NUM = H_SIZE * V_SIZE;

    // slot_ready[s] is the space flag of the buffer delivering into slot s.
    logic [NODES_NUM*4-1:0] slot_ready;

    for (genvar n = 0; n < NODES_NUM; n++) begin : g_node
        for (genvar p = 0; p < 4; p++) begin : g_port
            localparam int S = n * 4 + p;
            localparam int PEER = nb_node(n, p, H_SIZE, V_SIZE) * 4 + opposite(p);
`ifdef MESH_TORUS_EN
            localparam bit LINKED = 1'b1;
`else
            localparam bit LINKED = !on_edge(n, p, H_SIZE, V_SIZE);
`endif
            if (LINKED) begin : g_link
                mesh_link_fifo #(
                    .DATA_W    (DATA_W),
                    .LINK_DEPTH(LINK_DEPTH)
                ) u_fifo (
                    .clk    (clk),
                    .rst    (rst),
                    .valid_i(valid_i[PEER]),
                    .ready_o(slot_ready[S]),
                    .data_i (data_i[PEER*DATA_W +: DATA_W]),
                    .valid_o(valid_o[S]),
                    .ready_i(ready_i[S]),
                    .data_o (data_o[S*DATA_W +: DATA_W])
                );
                // The link leaving this port fills the peer's ingress buffer.
                assign ready_o[S] = slot_ready[PEER];
            end else begin : g_edge
                logic unused_edge;
                assign slot_ready[S]                 = 1'b0;
                assign ready_o[S]                    = 1'b0;
                assign valid_o[S]                    = 1'b0;
                assign data_o[S*DATA_W +: DATA_W]    = '0;
                assign unused_edge = ^{valid_i[S], ready_i[S], slot_ready[S], data_i[S*DATA_W +: DATA_W]};
            end
        end
    end
endmodule

// File: tb/tb_mesh_2d_pipe.sv
// tb_mesh_2d_pipe: randomized and directed checks of mesh_2d_pipe against a queue-based link model
module tb_mesh_2d_pipe;
    localparam int H = 2;
    localparam int V = 2;
    localparam int DW = 8;
    localparam int DEPTH = 2;
    localparam int NP = H * V * 4;
`ifdef MESH_TORUS_EN
    localparam logic [15:0] CONN = 16'hFFFF;
`else
    localparam logic [15:0] CONN = 16'hC963;
`endif

    logic            clk = 0;
    logic            rst;
    logic [NP*DW-1:0] data_i;
    logic [NP-1:0]    valid_i;
    logic [NP-1:0]    ready_o;
    logic [NP*DW-1:0] data_o;
    logic [NP-1:0]    valid_o;
    logic [NP-1:0]    ready_i;

    mesh_2d_pipe #(.H_SIZE(H), .V_SIZE(V), .DATA_W(DW), .LINK_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit model_ok = 0;
    logic [7:0] q [NP][$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Destination slot reached by a word leaving slot s, or -1 for an unconnected port.
    function automatic int peer(input int s);
        int n = s / 4;
        int p = s % 4;
        int nx = n % H;
        int ny = n / H;
        if (p == 0) nx++;
        else if (p == 2) nx--;
        else if (p == 1) ny++;
        else ny--;
`ifdef MESH_TORUS_EN
        nx = (nx + H) % H;
        ny = (ny + V) % V;
`else
        if (nx < 0 || nx >= H || ny < 0 || ny >= V) return -1;
`endif
        return (ny * H + nx) * 4 + (p + 2) % 4;
    endfunction

    // Called at a falling edge with inputs set: compare, advance one clock, update the model.
    task automatic cycle();
        logic [NP-1:0]    ev;
        logic [NP-1:0]    er;
        logic [NP*DW-1:0] ed;
        bit pop [NP];
        bit push [NP];
        for (int s = 0; s < NP; s++) begin
            int d = peer(s);
            ev[s] = q[s].size() > 0;
            ed[s*DW +: DW] = ev[s] ? q[s][0] : 8'h00;
            er[s] = d >= 0 && q[d >= 0 ? d : 0].size() < DEPTH;
        end
        if (model_ok) begin
            check("model_valid", valid_o, ev);
            check("model_ready", ready_o, er);
            check("model_data", data_o, ed);
        end
        @(posedge clk);
        if (rst) begin
            for (int s = 0; s < NP; s++) q[s].delete();
            model_ok = 1;
        end else begin
            for (int s = 0; s < NP; s++) begin
                pop[s]  = ev[s] && ready_i[s];
                push[s] = er[s] && valid_i[s];
            end
            for (int s = 0; s < NP; s++) if (pop[s]) void'(q[s].pop_front());
            for (int s = 0; s < NP; s++) if (push[s]) q[peer(s)].push_back(data_i[s*DW +: DW]);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] w [3];
        logic [7:0] got [$];
        int sent;
        bit acc;
        bit leak;
        w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33;
        rst = 1; valid_i = '0; data_i = '0; ready_i = '1;
        @(negedge clk);
        cycle();
        cycle();
        rst = 0;
        check("rst_valid", valid_o, 0);
        check("rst_ready", ready_o, CONN);
        check("rst_data", data_o, 0);

        // Single word east from node0 to node1 port west
        valid_i[0] = 1; data_i[7:0] = 8'hA5;
        cycle();
        valid_i = '0; data_i = '0;
        check("a5_valid", valid_o[6], 1);
        check("a5_data", data_o[55:48], 8'hA5);
        cycle();
        check("a5_gone", valid_o[6], 0);

        // Back-pressure on node0 south -> node2 north
        ready_i[11] = 0;
        sent = 0;
        for (int c = 0; c < 6; c++) begin
            valid_i[1] = 1; data_i[15:8] = w[sent];
            acc = ready_o[1];
            cycle();
            if (acc) sent++;
        end
        check("full_ready", ready_o[1], 0);
        check("full_sent", sent, 2);
        check("held_valid", valid_o[11], 1);
        check("held_head", data_o[95:88], 8'h11);
        ready_i[11] = 1;
        acc = ready_o[1];
        got.push_back(data_o[95:88]);
        cycle();
        check("pop_no_push", acc, 0);
        check("pop_reopens", ready_o[1], 1);
        for (int c = 0; c < 10; c++) begin
            valid_i[1] = sent < 3;
            data_i[15:8] = sent < 3 ? w[sent] : 8'h00;
            acc = ready_o[1] && valid_i[1];
            if (valid_o[11] && ready_i[11]) got.push_back(data_o[95:88]);
            cycle();
            if (acc) sent++;
        end
        valid_i = '0; data_i = '0;
        check("order_n", got.size(), 3);
        for (int i = 0; i < 3; i++) check("order", i < got.size() ? got[i] : 8'h00, w[i]);

        // Edge port node1 east
        valid_i[4] = 1; data_i[39:32] = 8'h5A;
`ifdef MESH_TORUS_EN
        check("edge_ready", ready_o[4], 1);
`else
        check("edge_ready", ready_o[4], 0);
`endif
        cycle();
        valid_i = '0; data_i = '0;
`ifdef MESH_TORUS_EN
        check("torus_valid", valid_o[2], 1);
        check("torus_data", data_o[23:16], 8'h5A);
`else
        check("edge_none", valid_o, 0);
`endif
        cycle();

        // Reset with words buffered for node3 north
        ready_i[15] = 0;
        valid_i[5] = 1; data_i[47:40] = 8'h77;
        cycle();
        data_i[47:40] = 8'h88;
        cycle();
        valid_i = '0; data_i = '0;
        check("pre_rst_held", valid_o[15], 1);
        rst = 1;
        cycle();
        rst = 0;
        check("rst2_valid", valid_o, 0);
        check("rst2_ready", ready_o, CONN);
        check("rst2_data", data_o, 0);
        ready_i = '1;
        leak = 0;
        for (int c = 0; c < 5; c++) begin
            if (valid_o[15]) leak = 1;
            cycle();
        end
        check("no_leak", leak, 0);

        for (int c = 0; c < 400; c++) begin
            rst = $urandom_range(0, 63) == 0;
            valid_i = NP'($urandom);
            ready_i = NP'($urandom) | NP'($urandom);
            data_i = {$urandom, $urandom, $urandom, $urandom};
            cycle();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
